mult_div_unit: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit for the ALU datapath. Latches operands on a

---
 rtl/mult_div_pkg.sv | 26 ++
 rtl/mult_div_unit_div_step.sv | 22 ++
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM states, op codes
// and the iteration-counter width helper.
package mult_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_t;

   function automatic int clog2(input int value);
      int r;
      r = 32'sd0;
      for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] partial_s;
   logic [WIDTH:0] diff_s;

   assign partial_s = {rem_in, dvd_bit};
   assign diff_s    = partial_s - {1'b0, divisor};
   assign q_bit     = ~diff_s[WIDTH];
   // The remainder stays below the divisor, so WIDTH bits always hold it.
   assign rem_out   = q_bit ? diff_s[WIDTH-1:0] : partial_s[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide: sign-magnitude shift-add and restoring
// shift-subtract loops, one bit per cycle, with a registered result and flag.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             result_rdy,
   output logic             busy
);

   localparam int CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // |MIN| comes out as the unsigned value 2^(WIDTH-1), which still fits WIDTH bits.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
   endfunction

   state_t             state_r, state_s;
   op_t                op_r;
   logic               start_ok_s;
   logic [CNT_W-1:0]   cnt_r;
   logic               neg_r, dvz_r;
   logic [2*WIDTH-1:0] acc_r, mcand_r;
   logic [WIDTH-1:0]   mplier_r, rem_r, dvd_r, dvs_r;
   logic [WIDTH-1:0]   rem_nxt_s;
   logic               q_bit_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic               mul_exc_s, div_exc_s;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (rem_r),
      .dvd_bit (dvd_r[WIDTH-1]),
      .divisor (dvs_r),
      .rem_out (rem_nxt_s),
      .q_bit   (q_bit_s)
   );

   assign prod_s    = neg_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
   assign quo_s     = neg_r ? (~dvd_r + {{(WIDTH-1){1'b0}}, 1'b1}) : dvd_r;
   assign mul_exc_s = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
   // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
   assign div_exc_s = ~neg_r & dvd_r[WIDTH-1];

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state and start acceptance
   always_comb begin
      state_s    = state_r;
      start_ok_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_mult ^ start_div) begin
               state_s    = ST_RUN;
               start_ok_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_FIX:  state_s = ST_DONE;
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath iteration and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         result     <= {WIDTH{1'b0}};
         exception  <= 1'b0;
         result_rdy <= 1'b0;
         busy       <= 1'b0;
         op_r       <= OP_MUL;
         cnt_r      <= {CNT_W{1'b0}};
         neg_r      <= 1'b0;
         dvz_r      <= 1'b0;
         acc_r      <= {(2*WIDTH){1'b0}};
         mcand_r    <= {(2*WIDTH){1'b0}};
         mplier_r   <= {WIDTH{1'b0}};
         rem_r      <= {WIDTH{1'b0}};
         dvd_r      <= {WIDTH{1'b0}};
         dvs_r      <= {WIDTH{1'b0}};
      end else begin
         result_rdy <= (state_r == ST_DONE);
         busy       <= (state_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  op_r     <= start_div ? OP_DIV : OP_MUL;
                  neg_r    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                  dvz_r    <= (operand_b == {WIDTH{1'b0}});
                  cnt_r    <= {CNT_W{1'b0}};
                  acc_r    <= {(2*WIDTH){1'b0}};
                  mcand_r  <= {{WIDTH{1'b0}}, mag(operand_a)};
                  mplier_r <= mag(operand_b);
                  rem_r    <= {WIDTH{1'b0}};
                  dvd_r    <= mag(operand_a);
                  dvs_r    <= mag(operand_b);
               end
            end
            ST_RUN: begin
               cnt_r <= cnt_r + CNT_W'(1);
               if (op_r == OP_MUL) begin
                  if (mplier_r[0]) begin
                     acc_r <= acc_r + mcand_r;
                  end
                  mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                  mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
               end else begin
                  rem_r <= rem_nxt_s;
                  dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
               end
            end
            ST_FIX: begin
               if (op_r == OP_MUL) begin
                  result    <= prod_s[WIDTH-1:0];
                  exception <= mul_exc_s;
               end else if (dvz_r) begin
                  result    <= {WIDTH{1'b0}};
                  exception <= 1'b1;
               end else begin
                  result    <= quo_s;
                  exception <= div_exc_s;
               end
            end
            ST_DONE: begin
               cnt_r <= {CNT_W{1'b0}};
            end
            default: begin
               cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, control corner
// cases and random operands against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          start_mult, start_div;
   logic [W-1:0]  operand_a, operand_b;
   logic [W-1:0]  result;
   logic          exception, result_rdy, busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic       is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        e;
   } vec_t;

   vec_t tab[12];

   always #5 clock = ~clock;

   mult_div_unit #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .result     (result),
      .exception  (exception),
      .result_rdy (result_rdy),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Reference: exact signed arithmetic in 64 bits, then the exception rules.
   function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint sa, sb, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) begin
         p = sa * sb;
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[31:0];
         e = 1'b0;
      end
   endfunction

   // mode: 0 normal, 1 both starts together; pulse_edge/rst_edge < 0 disable.
   task automatic run(input string name, input logic is_div, input logic [31:0] a,
                      input logic [31:0] b, input int mode, input int pulse_edge,
                      input int rst_edge, input int n_edges,
                      input logic [31:0] er, input logic ee);
      logic [31:0] cap_r;
      logic        cap_e;
      logic        exp_busy;
      int          rdy_edge, rdy_cnt, busy_bad;
      cap_r = 32'd0; cap_e = 1'b0;
      rdy_edge = -1; rdy_cnt = 0; busy_bad = 0;
      @(negedge clock);
      operand_a  = a;
      operand_b  = b;
      start_mult = (mode == 1) ? 1'b1 : !is_div;
      start_div  = (mode == 1) ? 1'b1 : is_div;
      @(posedge clock);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      for (int k = 1; k <= n_edges; k++) begin
         if (k == pulse_edge) begin
            @(negedge clock);
            start_div = 1'b1;
            operand_a = 32'd99;
            operand_b = 32'd3;
         end
         if (k == rst_edge) begin
            @(negedge clock);
            reset = 1'b1;
         end
         @(posedge clock);
         #1;
         start_div = 1'b0;
         reset     = 1'b0;
         exp_busy = (mode == 0) && (k <= 33) && !(rst_edge > 0 && k >= rst_edge);
         if (busy !== exp_busy) busy_bad++;
         if (result_rdy === 1'b1) begin
            rdy_cnt++;
            if (rdy_edge < 0) begin
               rdy_edge = k;
               cap_r = result;
               cap_e = exception;
            end
         end
         if (k == rst_edge) begin
            chk({name, " rst result"}, result, 32'd0);
            chk({name, " rst exception"}, {31'd0, exception}, 32'd0);
            chk({name, " rst rdy"}, {31'd0, result_rdy}, 32'd0);
            chk({name, " rst busy"}, {31'd0, busy}, 32'd0);
         end
      end
      chk({name, " busy profile errors"}, busy_bad, 32'd0);
      if (mode != 0 || rst_edge > 0) begin
         chk({name, " rdy pulses"}, rdy_cnt, 32'd0);
      end else begin
         chk({name, " rdy edge"}, rdy_edge, 32'd34);
         chk({name, " rdy pulses"}, rdy_cnt, 32'd1);
         chk({name, " result"}, cap_r, er);
         chk({name, " exception"}, {31'd0, cap_e}, {31'd0, ee});
         chk({name, " result hold"}, result, er);
      end
   endtask

   initial begin
      logic [31:0] ra, rb, rr;
      logic        re, rdiv;

      tab[0]  = '{"mul 7*-6",       1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
      tab[1]  = '{"mul 2^16*2^16",  1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
      tab[2]  = '{"mul -1*-1",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      tab[3]  = '{"div -43/5",      1'b1, 32'hFFFF_FFD5,  32'd5,         32'hFFFF_FFF8, 1'b0};
      tab[4]  = '{"div 43/-5",      1'b1, 32'd43,         32'hFFFF_FFFB, 32'hFFFF_FFF8, 1'b0};
      tab[5]  = '{"div 4/9",        1'b1, 32'd4,          32'd9,         32'h0000_0000, 1'b0};
      tab[6]  = '{"div 100/0",      1'b1, 32'd100,        32'd0,         32'h0000_0000, 1'b1};
      tab[7]  = '{"div MIN/-1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      tab[8]  = '{"mul MIN*1",      1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
      tab[9]  = '{"div MIN/1",      1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
      tab[10] = '{"mul MIN*MIN",    1'b0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1};
      tab[11] = '{"div 7/7",        1'b1, 32'd7,          32'd7,         32'h0000_0001, 1'b0};

      reset = 1'b1; start_mult = 1'b0; start_div = 1'b0;
      operand_a = 32'd0; operand_b = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset result", result, 32'd0);
      chk("reset exception", {31'd0, exception}, 32'd0);
      chk("reset rdy", {31'd0, result_rdy}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run(tab[i].name, tab[i].is_div, tab[i].a, tab[i].b, 0, -1, -1, 40, tab[i].r, tab[i].e);
      end

      run("both starts", 1'b0, 32'd5, 32'd5, 1, -1, -1, 40, 32'd0, 1'b0);
      run("mul with div pulse", 1'b0, 32'd7, 32'hFFFF_FFFA, 0, 5, -1, 40, 32'hFFFF_FFD6, 1'b0);
      run("reset mid-op", 1'b0, 32'h0000_1234, 32'h0000_0010, 0, -1, 10, 50, 32'd0, 1'b0);
      run("after reset", 1'b1, 32'd1000, 32'd7, 0, -1, -1, 40, 32'd142, 1'b0);

      for (int i = 0; i < 30; i++) begin
         rdiv = $urandom_range(1, 0) == 1;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(3, 0))
            0: rb = {{16{rb[15]}}, rb[15:0]};
            1: ra = {{20{ra[11]}}, ra[11:0]};
            2: rb = {{24{rb[7]}}, rb[7:0]};
            default: ;
         endcase
         model(rdiv, ra, rb, rr, re);
         run(rdiv ? "rand div" : "rand mul", rdiv, ra, rb, 0, -1, -1, 40, rr, re);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
